// File: rtl/sirv_plic_gateway_array_if.sv
// Port bundle of the PLIC gateway array.
// The master side drives the lines, the mode, ready and complete. The slave side (the gateways) returns valid and overflow.
interface sirv_plic_gateway_array_if #(
    parameter int NUM_SRC = 8
);
    logic [NUM_SRC-1:0] io_interrupt;
    logic [NUM_SRC-1:0] io_edge_mode;
    logic [NUM_SRC-1:0] io_plic_valid;
    logic [NUM_SRC-1:0] io_plic_ready;
    logic [NUM_SRC-1:0] io_plic_complete;
    logic [NUM_SRC-1:0] io_edge_ovf;

    modport master (
        output io_interrupt, io_edge_mode, io_plic_ready, io_plic_complete,
        input  io_plic_valid, io_edge_ovf
    );

    modport slave (
        input  io_interrupt, io_edge_mode, io_plic_ready, io_plic_complete,
        output io_plic_valid, io_edge_ovf
    );
endinterface

// File: rtl/sirv_plic_gateway_array.sv
// Bank of PLIC gateways, one per source. Each source runs in level mode or in rising-edge mode with a saturating count of pending edges.
// Defining SIRV_PLIC_GATEWAY_SYNC_EN inserts a 2-flop synchroniser on every io_interrupt bit.
module sirv_plic_gateway_array #(
    parameter int NUM_SRC = 8,
    parameter int CNT_W   = 3
) (
    input logic                      clk,
    input logic                      rst_n,
    sirv_plic_gateway_array_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [NUM_SRC-1:0] w_line;

`ifdef SIRV_PLIC_GATEWAY_SYNC_EN
    logic [NUM_SRC-1:0] r_sync1;
    logic [NUM_SRC-1:0] r_sync2;

    // NOTE: flops use non-blocking assignments so each stage samples the pre-edge value of the previous one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= bus.io_interrupt;
            r_sync2 <= r_sync1;
        end
    end

    assign w_line = r_sync2;
`else
    assign w_line = bus.io_interrupt;
`endif

    logic [NUM_SRC-1:0]            r_in_flight;
    logic [NUM_SRC-1:0]            r_prev;
    logic [NUM_SRC-1:0]            r_mode_q;
    logic [NUM_SRC-1:0]            r_ovf;
    logic [NUM_SRC-1:0][CNT_W-1:0] r_cnt;

    logic [NUM_SRC-1:0]            w_valid;
    logic [NUM_SRC-1:0]            w_accept;
    logic [NUM_SRC-1:0]            w_edge;
    logic [NUM_SRC-1:0]            w_in_flight_nxt;
    logic [NUM_SRC-1:0]            w_ovf_nxt;
    logic [NUM_SRC-1:0][CNT_W-1:0] w_cnt_nxt;

    always_comb begin
        // NOTE: every target gets a default before the loop, so no path can leave a bit unassigned and infer a latch.
        w_valid         = '0;
        w_accept        = '0;
        w_edge          = '0;
        w_in_flight_nxt = r_in_flight;
        w_ovf_nxt       = '0;
        w_cnt_nxt       = r_cnt;
        for (int i = 0; i < NUM_SRC; i++) begin
            w_edge[i]   = r_mode_q[i] & w_line[i] & ~r_prev[i];
            w_valid[i]  = ~r_in_flight[i] & (r_mode_q[i] ? (r_cnt[i] != '0) : w_line[i]);
            w_accept[i] = w_valid[i] & bus.io_plic_ready[i];
            if (bus.io_edge_mode[i] != r_mode_q[i]) begin
                // A mode switch drops the outstanding claim and any pending edges.
                w_cnt_nxt[i]       = '0;
                w_in_flight_nxt[i] = 1'b0;
            end else begin
                if (bus.io_plic_complete[i]) begin
                    w_in_flight_nxt[i] = 1'b0;
                end else if (w_accept[i]) begin
                    w_in_flight_nxt[i] = 1'b1;
                end

                if (!r_mode_q[i]) begin
                    w_cnt_nxt[i] = '0;
                end else if (w_edge[i] && !w_accept[i]) begin
                    if (r_cnt[i] == CNT_MAX) begin
                        w_ovf_nxt[i] = 1'b1;
                    end else begin
                        w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
                    end
                end else if (!w_edge[i] && w_accept[i]) begin
                    w_cnt_nxt[i] = r_cnt[i] - CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_flight <= '0;
            r_prev      <= '0;
            r_mode_q    <= '0;
            r_ovf       <= '0;
            // NOTE: the counters are ordinary flops rather than a RAM, so reset clears them with the rest of the channel state.
            r_cnt       <= '0;
        end else begin
            r_in_flight <= w_in_flight_nxt;
            r_prev      <= w_line;
            r_mode_q    <= bus.io_edge_mode;
            r_ovf       <= w_ovf_nxt;
            r_cnt       <= w_cnt_nxt;
        end
    end

    assign bus.io_plic_valid = w_valid;
    assign bus.io_edge_ovf   = r_ovf;
endmodule
